// File: rtl/shift_sequencer_pkg.sv
// rtl/shift_sequencer_pkg.sv - shared mode codes, FSM states and width defaults
package shift_sequencer_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 4;

  localparam logic [2:0] OP_CLR = 3'd0;
  localparam logic [2:0] OP_LD  = 3'd1;
  localparam logic [2:0] OP_SRL = 3'd2;
  localparam logic [2:0] OP_SLL = 3'd3;
  localparam logic [2:0] OP_SRA = 3'd4;
  localparam logic [2:0] OP_SRI = 3'd5;
  localparam logic [2:0] OP_ROR = 3'd6;
  localparam logic [2:0] OP_ROL = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_SHIFT  = 2'd2,
    S_FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - command handshake bus into the sequencer
interface shift_sequencer_if
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic             cmd_load;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_count;
  logic             cmd_fill;

  modport master (
    output cmd_valid, cmd_op, cmd_load, cmd_data, cmd_count, cmd_fill,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_load, cmd_data, cmd_count, cmd_fill,
    output cmd_ready
  );
endinterface

// File: rtl/shift_sequencer_count.sv
// rtl/shift_sequencer_count.sv - loadable down-counter with zero and last-step flags
module shift_count
  import shift_sequencer_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o,
  output logic             last_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && !zero_o) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);
  assign last_o = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - command-driven sequencer for the 8-bit shift register
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  shift_sequencer_if.slave cmd,
  output logic [2:0]       sh_chos,
  output logic [WIDTH-1:0] sh_inp,
  output logic             sh_left,
  input  logic [WIDTH-1:0] sh_result,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_out
);
  localparam logic [1:0] ST_IDLE   = S_IDLE;
  localparam logic [1:0] ST_LOAD   = S_LOAD;
  localparam logic [1:0] ST_SHIFT  = S_SHIFT;
  localparam logic [1:0] ST_FINISH = S_FINISH;

  logic [1:0]       state_q, state_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic             fill_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             ready_c;
  logic             accept;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             cnt_last;

  assign accept = cmd.cmd_valid && ready_c;

  shift_count #(.CNT_W(CNT_W)) u_count (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept),
    .load_val_i (cmd.cmd_count),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero),
    .last_o     (cnt_last)
  );

  // The register has no hold code, so every non-working cycle reloads its own output.
  always_comb begin
    state_d = state_q;
    sh_chos = OP_LD;
    sh_inp  = sh_result;
    sh_left = 1'b0;
    ready_c = 1'b0;
    busy    = 1'b1;
    cnt_dec = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_c = 1'b1;
        busy    = 1'b0;
        if (accept) begin
          if (cmd.cmd_op < OP_SRL || cmd.cmd_load) begin
            state_d = ST_LOAD;
          end else if (cmd.cmd_count != '0) begin
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_LOAD: begin
        sh_chos = (op_q == OP_CLR) ? OP_CLR : OP_LD;
        sh_inp  = data_q;
        state_d = (op_q >= OP_SRL && !cnt_zero) ? ST_SHIFT : ST_FINISH;
      end
      ST_SHIFT: begin
        sh_chos = op_q;
        sh_left = (op_q == OP_SRI) && fill_q;
        cnt_dec = 1'b1;
        if (cnt_last) begin
          state_d = ST_FINISH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (rst) begin
      sh_chos = OP_CLR;
      sh_left = 1'b0;
      ready_c = 1'b0;
      busy    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_CLR;
      data_q   <= '0;
      fill_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == ST_FINISH);
      if (state_q == ST_FINISH) begin
        result_q <= sh_result;
      end
      if (accept) begin
        op_q   <= cmd.cmd_op;
        data_q <= cmd.cmd_data;
        fill_q <= cmd.cmd_fill;
      end
    end
  end

  assign cmd.cmd_ready = ready_c;
  assign done          = done_q;
  assign result_out    = result_q;
endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

- Command-driven controller for the team's 8-bit shift register.
- Mode-select codes of that register: 0 clear, 1 load, 2 logical right, 3 logical left, 4 arithmetic right, 5 right with serial-in, 6 rotate right, 7 rotate left.
- Accepts one command at a time over a valid/ready handshake, optionally loads a seed value, then applies a chosen shift mode a programmed number of times and reports the result with a done pulse.
- Sits between the front-panel/command logic and the shift register. The shift register has no hold code, so this block holds its contents by reloading them.

## Interface
- WIDTH, 8, datapath width (matches shift register)
- CNT_W, 4, shift-count width; 0..2^CNT_W-1 shifts per command
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command this cycle
- cmd_op  in  3  mode code 0..7 as above
- cmd_load  in  1  load cmd_data before shifting (ignored for op 0/1)
- cmd_data  in  WIDTH  seed value / load value
- cmd_count  in  CNT_W  number of shift cycles (ignored for op 0/1)
- cmd_fill  in  1  serial-in bit for op 5
- sh_chos  out  3  mode select to shift register
- sh_inp  out  WIDTH  parallel input to shift register
- sh_left  out  1  serial-in to shift register
- sh_result  in  WIDTH  shift register contents
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- result_out  out  WIDTH  result captured at completion

## Operation
- FSM states: IDLE, LOAD, SHIFT, FINISH.
- Command fields are latched on acceptance (cmd_valid && cmd_ready).
- IDLE:
  - cmd_ready=1, busy=0.
  - Drives sh_chos=1, sh_inp=sh_result, which acts as a hold.
  - On acceptance:
    - op 0/1 → LOAD.
    - op 2..7 with load=1 → LOAD.
    - op 2..7 with load=0 and count>0 → SHIFT.
    - op 2..7 with load=0 and count=0 → FINISH.
- LOAD, one cycle:
  - sh_chos = 0 for op 0, otherwise 1; sh_inp = latched data.
  - Next state: SHIFT if op≥2 and count>0, else FINISH.
- SHIFT:
  - sh_chos = latched op; sh_left = latched fill.
  - Remaining-count register decrements each cycle; exits to FINISH after exactly count cycles.
- FINISH, one cycle:
  - Drives the hold code.
  - result_out <= sh_result; done <= 1 at the edge leaving FINISH.
  - Returns to IDLE.
- cmd_ready=0 and busy=1 in LOAD, SHIFT and FINISH. A cmd_valid offered then is not accepted; the requester must hold it.
- sh_left=0 whenever the block is not in SHIFT with op 5.
- Reset:
  - While rst=1: sh_chos=0 (the shift register clears on that edge), cmd_ready=0, busy=0.
  - State after reset: IDLE; done=0; result_out=0; count register=0.
  - Reset mid-command abandons the command with no done pulse.

## Timing
- Acceptance edge E0. With load and N shifts:
  - LOAD spans E0–E1.
  - Shifts occur at E2..E(N+1).
  - FINISH spans E(N+1)–E(N+2).
  - done=1 and result_out valid in the cycle after E(N+2), i.e. latency N+2 cycles.
- Without load: latency N+1 cycles.
- Op 0/1: latency 2 cycles.
- Count 0 with load=0: latency 1 cycle.
- The cycle in which done=1 is IDLE, with cmd_ready=1, so back-to-back commands are legal. A command accepted in that cycle does not disturb result_out until its own FINISH.
- result_out holds its value until the next completion.
- Outputs done, result_out and state are registered. sh_chos, sh_inp, sh_left, cmd_ready and busy are combinational from state and rst.

## Structure
- Shared package contains:
  - mode-code constants (OP_CLR=0 … OP_ROL=7);
  - the FSM state enum;
  - the WIDTH/CNT_W defaults.
- Natural sub-module: shift_count, a loadable down-counter with zero flag, CNT_W wide.
- The top-level testbench instantiates shift_sequencer with the existing shift register.

## Test plan
- Load 0x96, op 4, count 2 → result_out=0xE5, done exactly 4 cycles after acceptance.
- Load 0x81, op 7, count 3 → 0x0C; shift register observed as 0x03, 0x06, 0x0C on successive edges.
- Op 0 after any value → result 0x00; then load=0, op 5, fill=1, count 8 → 0xFF, latency 9.
- Load 0x5A, count 0 → 0x5A at latency 2; idle 20 cycles → sh_result stays 0x5A; cmd_valid held during busy → accepted only once cmd_ready returns.
- Reset during SHIFT of a count-10 command → no done pulse; sh_result=0x00, result_out=0x00; cmd_ready=1 first cycle after rst falls.
- Back-to-back: second command (op 3, load 0x01, count 4) accepted in the done cycle of the first → result 0x10; first result held until then.
